// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes and FSM states.
// Optional early-exit divide is selected by defining MULDIV_EARLY_EXIT_EN.
package hilo_muldiv_pkg;

  localparam int unsigned XLEN = 32;

  // Codes sit above the existing ALU op range so the shared op bus stays unambiguous.
  localparam logic [4:0] ALU_MULT  = 5'h14;
  localparam logic [4:0] ALU_MULTU = 5'h15;
  localparam logic [4:0] ALU_DIV   = 5'h16;
  localparam logic [4:0] ALU_DIVU  = 5'h17;
  localparam logic [4:0] ALU_MTHI  = 5'h18;
  localparam logic [4:0] ALU_MTLO  = 5'h19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } md_state_e;

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Radix-2 restoring divider datapath: one shift/trial-subtract step per cycle on
// unsigned magnitudes. Early-exit divides (MULDIV_EARLY_EXIT_EN in the top) finish in one step.
module div_radix2 #(
  parameter int unsigned DIV_ITERS = 32,
  parameter int unsigned W         = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         flush_i,
  input  logic         early_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o,
  output logic         done_o
);

  localparam int unsigned CW = $clog2(DIV_ITERS);

  logic          run_q, run_d;
  logic          early_q, early_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;

  logic [W:0]    rem_sh;
  logic [W+1:0]  diff;
  logic [W-1:0]  step_rem;
  logic [W-1:0]  step_quo;
  logic          last;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    if (diff[W+1]) begin
      step_rem = rem_sh[W-1:0];
      step_quo = {quo_q[W-2:0], 1'b0};
    end else begin
      step_rem = diff[W-1:0];
      step_quo = {quo_q[W-2:0], 1'b1};
    end
  end

  assign last   = early_q | (cnt_q == CW'(DIV_ITERS - 1));
  assign done_o = run_q & last;

  // Early exit: quotient is all-ones for a zero divisor, else zero; remainder is the dividend.
  assign quo_o = early_q ? ((dvs_q == '0) ? '1 : '0) : step_quo;
  assign rem_o = early_q ? quo_q : step_rem;

  always_comb begin
    run_d   = run_q;
    early_d = early_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    if (flush_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d   = 1'b1;
      early_d = early_i;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = dividend_i;
      dvs_d   = divisor_i;
    end else if (run_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      early_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      run_q   <= run_d;
      early_q <= early_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO.
// Define MULDIV_EARLY_EXIT_EN to finish zero-divisor and |a|<|b| divides in one step.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  input  logic        start,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        ready
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;

  logic        is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_divx;
  logic        issue, div_start, b_zero, early;
  logic [31:0] mag_a, mag_b, dividend;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
  logic        div_done;

  assign is_mult  = (op == ALU_MULT);
  assign is_multu = (op == ALU_MULTU);
  assign is_div   = (op == ALU_DIV);
  assign is_divu  = (op == ALU_DIVU);
  assign is_mthi  = (op == ALU_MTHI);
  assign is_mtlo  = (op == ALU_MTLO);
  assign is_divx  = is_div | is_divu;

  assign issue     = (state_q == IDLE) & start & ~flush;
  assign div_start = issue & is_divx;
  assign busy      = div_start | (state_q == DIV_RUN);
  assign ready     = (state_q == DONE);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign b_zero = (b == '0);
  assign mag_a  = (is_div & a[31]) ? (~a + 32'd1) : a;
  assign mag_b  = (is_div & b[31]) ? (~b + 32'd1) : b;
  // A zero divisor feeds the raw dividend so the remainder comes out as a unchanged.
  assign dividend = b_zero ? a : mag_a;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early = b_zero | (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  div_radix2 #(
    .DIV_ITERS (DIV_ITERS),
    .W         (XLEN)
  ) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .flush_i    (flush),
    .early_i    (early),
    .dividend_i (dividend),
    .divisor_i  (mag_b),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .done_o     (div_done)
  );

  assign quo_fix = qsign_q ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix = rsign_q ? (~div_rem + 32'd1) : div_rem;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (is_mult) begin
            {hi_d, lo_d} = prod_s;
          end else if (is_multu) begin
            {hi_d, lo_d} = prod_u;
          end else if (is_mthi) begin
            hi_d = a;
          end else if (is_mtlo) begin
            lo_d = a;
          end else if (is_divx) begin
            state_d = DIV_RUN;
            qsign_d = is_div & ~b_zero & (a[31] ^ b[31]);
            rsign_d = is_div & ~b_zero & a[31];
          end
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (div_done) begin
          lo_d    = quo_fix;
          hi_d    = rem_fix;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage companion to the ALU. It takes the same forwarded operands a/b and the same 5-bit op bus, and owns the architectural HI/LO registers.
- Performs MULT/MULTU in a single cycle, DIV/DIVU with an iterative radix-2 restoring divider, and MTHI/MTLO writes.
- Drives a stall request to the hazard unit while a divide runs.
- Its hi/lo outputs feed the MFHI/MFLO path into the EX result mux.

Parameters:
- DIV_ITERS, 32, number of divider iterations; equals the operand width and is fixed by the ISA.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- a  in  32  first operand (rs, forwarded)
- b  in  32  second operand (rt, forwarded)
- op  in  5  ALU select; this block acts only on alu_mult, alu_multu, alu_div, alu_divu, alu_mthi, alu_mtlo
- start  in  1  EX-stage instruction valid and not stalled by another source
- flush  in  1  EX flush (exception or branch squash)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  stall request
- ready  out  1  one-cycle pulse when a divide commits

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, state=IDLE, busy=0, ready=0; all divider datapath registers cleared. Reset mid-divide aborts it with no HI/LO write.
- States: IDLE, DIV_RUN, DONE.
- IDLE:
  - start & mult/multu: at the next edge {hi,lo} = 64-bit product (signed or unsigned); busy stays 0.
  - start & mthi: hi=a at the next edge. start & mtlo: lo=a at the next edge.
  - start & div/divu: latch |a|, |b| (raw values for divu), quotient sign = a[31]^b[31], remainder sign = a[31] (both forced 0 for divu); go to DIV_RUN.
- busy is combinational: (state==IDLE & start & op is div/divu & ~flush) | state==DIV_RUN.
  - The divide's own issue cycle therefore already stalls the pipeline.
- DIV_RUN:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract divisor, set quotient bit.
  - Iteration counter runs 0..DIV_ITERS-1. After the last step, lo=signed-fixed quotient and hi=signed-fixed remainder on the same edge; go to DONE.
- DONE: ready=1 and busy=0 for this cycle; return to IDLE at the next edge.
  - A new start in DONE is ignored; the pipeline has just been released and re-issues from IDLE.
- Timing: issue cycle 0; HI/LO updated at the edge ending cycle 32; ready high in cycle 33; busy high in cycles 0..32 (33 cycles).
- flush:
  - In IDLE, suppresses all writes.
  - In DIV_RUN, returns to IDLE at the next edge with HI/LO unchanged and no ready pulse.
  - flush has priority over start and over completion.
- start during DIV_RUN is ignored; the pipeline is stalled.
- Divide by zero (b=0): runs the full sequence with no sign fixup; lo=32'hFFFFFFFF, hi=a.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
- MFHI/MFLO issued in the cycle after a HI/LO write read the new value (register output, no bypass needed).

Optional Feature:
- MULDIV_EARLY_EXIT_EN
  - Defined: on div issue, if b==0 or |a|<|b| (unsigned compare of the magnitudes), DIV_RUN lasts one cycle. Results are lo=0, hi=a for |a|<|b|, and the divide-by-zero values above for b==0. busy lasts 2 cycles, ready appears in cycle 2.
  - Undefined: every divide takes the full 33-cycle busy window; results are identical either way.

Decomposition:
- defines.vh: alu_mult, alu_multu, alu_div, alu_divu, alu_mthi, alu_mtlo encodings (distinct from existing ALU codes), the state encodings, and the MULDIV_EARLY_EXIT_EN switch.
- One sub-module, div_radix2: the iteration datapath with counter, shift/subtract and done flag, taking start/flush and returning raw quotient and remainder.
- Sign handling, the multiplier and HI/LO registers stay in hilo_muldiv.

Test Plan:
- multu a=0xFFFFFFFF b=2 -> next cycle hi=0x00000001, lo=0xFFFFFFFE, busy never 1. mult with the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- divu a=7 b=2 -> busy cycles 0..32, lo=3, hi=1 after the cycle-32 edge, ready pulse in cycle 33 only.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=5 b=0 -> lo=0xFFFFFFFF, hi=5. With MULDIV_EARLY_EXIT_EN: the same result with busy for 2 cycles; divu 3/10 -> lo=0, hi=3, 2 busy cycles.
- hi/lo preloaded via mthi=0x11, mtlo=0x22; divu 100/7, flush asserted in cycle 10 -> state IDLE in cycle 11, hi=0x11, lo=0x22, no ready pulse.
- rst asserted asynchronously mid-cycle during DIV_RUN (cycle 15) -> hi=lo=0 and busy=0 immediately. After release, mtlo a=0xABCD -> lo=0xABCD next cycle.
